// File: rtl/gpu_mem_pkg.sv
// Shared types and defaults for the GPU memory responder.
// The optional perf counters are enabled with GPU_MEM_PERF_EN.
package gpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_ADDR_WIDTH  = 8;
    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_MEM_LATENCY = 2;
    localparam int PERF_W          = 16;

    // Saturating increment for the perf counters.
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/gpu_mem_responder_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or
// after ptr, wrapping. Pointer state lives in the caller.
module rr_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    int unsigned j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        j         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (!any && req[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/gpu_mem_responder.sv
// Round-robin memory responder: one transaction at a time, fixed latency,
// one-cycle response pulse. Define GPU_MEM_PERF_EN for read/write counters.
module gpu_mem_responder
    import gpu_mem_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0]                  req_we,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [NUM_REQ-1:0]                  resp_valid,
    output logic [DATA_WIDTH-1:0]               resp_rdata,
    output logic                                busy
`ifdef GPU_MEM_PERF_EN
    ,
    output logic [PERF_W-1:0]                   perf_reads,
    output logic [PERF_W-1:0]                   perf_writes
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef struct packed {
        logic [IDX_W-1:0]      idx;
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } txn_t;

    mem_state_t            state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [CNT_W-1:0]      cnt;
    txn_t                  cur;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [NUM_REQ-1:0]    arb_grant;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_any;
    logic                  commit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // Accept strobe is combinational so a requester sees it in the grant cycle.
    assign req_ready = (state == IDLE) ? arb_grant : '0;
    assign busy      = (state != IDLE);
    assign commit    = (state == BUSY) && (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cnt        <= '0;
            cur        <= '0;
            resp_valid <= '0;
            resp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        cur <= '{idx:   arb_idx,
                                 we:    req_we[arb_idx],
                                 addr:  req_addr[arb_idx],
                                 wdata: req_wdata[arb_idx]};
                        cnt   <= CNT_W'(MEM_LATENCY - 1);
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state      <= RESP;
                        resp_valid <= NUM_REQ'(1) << cur.idx;
                        // Reads sample the pre-commit word; writes echo their data.
                        resp_rdata <= cur.we ? cur.wdata : mem[cur.addr];
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= '0;
                    rr_ptr     <= (cur.idx == IDX_W'(NUM_REQ - 1)) ? '0 : cur.idx + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is not reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (rst_n && commit && cur.we)
            mem[cur.addr] <= cur.wdata;
    end

`ifdef GPU_MEM_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_reads  <= '0;
            perf_writes <= '0;
        end else if (state == RESP) begin
            if (cur.we) perf_writes <= sat_inc(perf_writes);
            else        perf_reads  <= sat_inc(perf_reads);
        end
    end
`endif

endmodule

// File: tb/tb_gpu_mem_responder.sv
// Directed bench for gpu_mem_responder with a transaction-level reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_gpu_mem_responder;
    import gpu_mem_pkg::*;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int L  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N-1:0]         req_valid = '0;
    logic [N-1:0]         req_we = '0;
    logic [N-1:0][AW-1:0] req_addr = '0;
    logic [N-1:0][DW-1:0] req_wdata = '0;
    logic [N-1:0]         req_ready;
    logic [N-1:0]         resp_valid;
    logic [DW-1:0]        resp_rdata;
    logic                 busy;
`ifdef GPU_MEM_PERF_EN
    logic [PERF_W-1:0]    perf_reads;
    logic [PERF_W-1:0]    perf_writes;
`endif

    gpu_mem_responder #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(L)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .busy(busy)
`ifdef GPU_MEM_PERF_EN
        , .perf_reads(perf_reads), .perf_writes(perf_writes)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-requester stimulus queues.
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } item_t;
    item_t  qi [N][32];
    int     head [N];
    int     tail [N];
    logic [N-1:0] ready_seen = '0;

    task automatic push(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        qi[i][tail[i]] = '{we, a, d};
        tail[i]++;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < N; i++) begin
            if (ready_seen[i]) head[i]++;
            if (head[i] < tail[i]) begin
                req_valid[i] = 1'b1;
                req_we[i]    = qi[i][head[i]].we;
                req_addr[i]  = qi[i][head[i]].addr;
                req_wdata[i] = qi[i][head[i]].data;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    end

    // Reference model: one outstanding transaction, response L+1 cycles after accept.
    logic [DW-1:0] mm [256];
    bit            m_pend = 0;
    int            m_ptr = 0;
    int            m_idx, m_rcyc;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;
    logic [DW-1:0] m_last = '0;
    int            m_reads = 0, m_writes = 0;

    int            glog_idx[$], glog_cyc[$];
    int            rlog_idx[$], rlog_cyc[$];
    logic [DW-1:0] rlog_data[$];

    initial forever begin
        @(negedge clk);
        ready_seen = req_ready;
        if (cyc >= 1) begin
            int g;
            logic [N-1:0] exp_ready, exp_resp;
            bit resp_now;
            g = -1;
            exp_ready = '0;
            exp_resp = '0;
            resp_now = 0;
            if (!m_pend) begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (g < 0 && req_valid[j]) g = j;
                end
                if (g >= 0) exp_ready[g] = 1'b1;
            end
            if (m_pend && cyc == m_rcyc) begin
                resp_now = 1;
                exp_resp[m_idx] = 1'b1;
                if (m_we) begin
                    mm[m_addr] = m_wd;
                    m_last = m_wd;
                end else begin
                    m_last = mm[m_addr];
                end
            end
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("busy", 32'(busy), 32'(m_pend));
            chk("resp_valid", 32'(resp_valid), 32'(exp_resp));
            chk("resp_rdata", 32'(resp_rdata), 32'(m_last));
`ifdef GPU_MEM_PERF_EN
            chk("perf_reads", 32'(perf_reads), 32'(m_reads));
            chk("perf_writes", 32'(perf_writes), 32'(m_writes));
`endif
            for (int k = 0; k < N; k++) begin
                if (req_ready[k]) begin glog_idx.push_back(k); glog_cyc.push_back(cyc); end
                if (resp_valid[k]) begin
                    rlog_idx.push_back(k); rlog_cyc.push_back(cyc); rlog_data.push_back(resp_rdata);
                end
            end
            if (resp_now) begin
                m_pend = 0;
                m_ptr = (m_idx + 1) % N;
                if (m_we) m_writes++; else m_reads++;
            end
            if (g >= 0) begin
                m_pend = 1;
                m_idx  = g;
                m_we   = req_we[g];
                m_addr = req_addr[g];
                m_wd   = req_wdata[g];
                m_rcyc = cyc + L + 1;
            end
            if (!rst_n) begin
                m_pend = 0; m_ptr = 0; m_last = '0; m_reads = 0; m_writes = 0;
            end
        end
    end

    function automatic bit drained();
        for (int i = 0; i < N; i++) if (head[i] < tail[i]) return 0;
        return !m_pend;
    endfunction

    task automatic wait_idle(input string name, input int bound);
        int n;
        n = 0;
        do begin
            @(negedge clk); #2; n++;
        end while (!drained() && n < bound);
        if (!drained()) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: timeout after %0d cycles, expected idle", name, bound);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    function automatic int gi(input int k);
        return (k < glog_idx.size()) ? glog_idx[k] : -1;
    endfunction
    function automatic int gc(input int k);
        return (k < glog_cyc.size()) ? glog_cyc[k] : -1;
    endfunction
    function automatic int ri(input int k);
        return (k < rlog_idx.size()) ? rlog_idx[k] : -1;
    endfunction
    function automatic int rc(input int k);
        return (k < rlog_cyc.size()) ? rlog_cyc[k] : -1;
    endfunction
    function automatic logic [DW-1:0] rd(input int k);
        return (k < rlog_data.size()) ? rlog_data[k] : 16'hDEAD;
    endfunction

    initial begin
        int g0, r0, n;
        for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #2;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_rdata", 32'(resp_rdata), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // Write then read back from requester 0.
        g0 = glog_idx.size(); r0 = rlog_idx.size();
        push(0, 1'b1, 8'h10, 16'hBEEF);
        push(0, 1'b0, 8'h10, 16'h0000);
        wait_idle("p1_idle", 40);
        chk("p1_latency", 32'(rc(r0) - gc(g0)), 32'd3);
        chk("p1_wr_idx", 32'(ri(r0)), 32'd0);
        chk("p1_rd_idx", 32'(ri(r0 + 1)), 32'd0);
        chk("p1_rd_data", 32'(rd(r0 + 1)), 32'hBEEF);

        // All four requesters valid after reset: order 0,1,2,3,0 spaced 4 cycles.
        do_reset();
        g0 = glog_idx.size();
        for (int i = 0; i < N; i++) push(i, 1'b1, 8'(8'h30 + i), 16'(16'h0100 + i));
        push(0, 1'b1, 8'h34, 16'h0200);
        wait_idle("p2_idle", 60);
        chk("p2_g0", 32'(gi(g0)), 32'd0);
        chk("p2_g1", 32'(gi(g0 + 1)), 32'd1);
        chk("p2_g2", 32'(gi(g0 + 2)), 32'd2);
        chk("p2_g3", 32'(gi(g0 + 3)), 32'd3);
        chk("p2_g4", 32'(gi(g0 + 4)), 32'd0);
        for (int k = 1; k < 5; k++) chk("p2_spacing", 32'(gc(g0 + k) - gc(g0 + k - 1)), 32'd4);

        // Pointer wrap: req3 alone, then req0 and req3 together.
        g0 = glog_idx.size(); r0 = rlog_idx.size();
        push(3, 1'b1, 8'h40, 16'h0777);
        wait_idle("p3a_idle", 40);
        push(0, 1'b0, 8'h30, 16'h0000);
        push(3, 1'b0, 8'h33, 16'h0000);
        wait_idle("p3b_idle", 40);
        chk("p3_g0", 32'(gi(g0)), 32'd3);
        chk("p3_g1", 32'(gi(g0 + 1)), 32'd0);
        chk("p3_g2", 32'(gi(g0 + 2)), 32'd3);
        chk("p3_rd0", 32'(rd(r0 + 1)), 32'h0100);
        chk("p3_rd3", 32'(rd(r0 + 2)), 32'h0103);

        // Cross-requester read-after-write.
        g0 = glog_idx.size(); r0 = rlog_idx.size();
        push(1, 1'b1, 8'hFF, 16'h1234);
        push(2, 1'b0, 8'hFF, 16'h0000);
        wait_idle("p4_idle", 40);
        chk("p4_g0", 32'(gi(g0)), 32'd1);
        chk("p4_g1", 32'(gi(g0 + 1)), 32'd2);
        chk("p4_rd_idx", 32'(ri(r0 + 1)), 32'd2);
        chk("p4_rd_data", 32'(rd(r0 + 1)), 32'h1234);

        // Reset while a write is in BUSY: it must not commit or respond.
        push(0, 1'b1, 8'h20, 16'h5555);
        wait_idle("p5a_idle", 40);
        r0 = rlog_idx.size();
        g0 = glog_idx.size();
        push(0, 1'b1, 8'h20, 16'hAAAA);
        n = 0;
        do begin @(negedge clk); #2; n++; end while (glog_idx.size() == g0 && n < 20);
        chk("p5_granted", 32'(glog_idx.size() - g0), 32'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); #2;
        chk("p5_rst_busy", 32'(busy), 32'h0);
        chk("p5_rst_resp", 32'(resp_valid), 32'h0);
        chk("p5_rst_rdata", 32'(resp_rdata), 32'h0);
        repeat (6) @(negedge clk);
        #2 chk("p5_no_resp", 32'(rlog_idx.size() - r0), 32'd0);
        push(0, 1'b0, 8'h20, 16'h0000);
        wait_idle("p5b_idle", 40);
        chk("p5_rd_data", 32'(rd(r0)), 32'h5555);

`ifdef GPU_MEM_PERF_EN
        do_reset();
        push(0, 1'b1, 8'h50, 16'h0001);
        push(1, 1'b1, 8'h51, 16'h0002);
        push(2, 1'b1, 8'h52, 16'h0003);
        push(3, 1'b0, 8'h50, 16'h0000);
        push(3, 1'b0, 8'h20, 16'h0000);
        wait_idle("perf_idle", 80);
        @(negedge clk); #2;
        chk("perf_writes_lit", 32'(perf_writes), 32'd3);
        chk("perf_reads_lit", 32'(perf_reads), 32'd2);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
